// File: rtl/microbenchmark_status_reader.sv
// AXI4-Lite read responder exposing engine completion, request counts and run cycles.
// Optional STATUS_CLEAR_ON_READ_EN: a read of STATUS clears the sticky done flags.
module microbenchmark_status_reader #(
    parameter int unsigned AXIL_DATA_BITS = 64,
    parameter int unsigned AXI_ADDR_BITS  = 8,
    parameter int unsigned N_ENGINES      = 16
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      axi_l_arvalid,
    input  logic [AXI_ADDR_BITS-1:0]  axi_l_araddr,
    output logic                      axi_l_arready,
    output logic                      axi_l_rvalid,
    input  logic                      axi_l_rready,
    output logic [AXIL_DATA_BITS-1:0] axi_l_rdata,
    output logic [1:0]                axi_l_rresp,
    input  logic [15:0]               ap_start,
    input  logic [15:0]               eng_done,
    input  logic [15:0]               req_done
);

    localparam int unsigned NE_MAX   = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned WIDE_W   = 64;
    localparam logic [15:0] ENG_MASK = 16'((33'd1 << N_ENGINES) - 33'd1);
    localparam logic [WIDE_W-1:0] ID_VALUE = 64'h0000_0000_4D42_5354;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, RESP} state_e;

    state_e              state_q, state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [WIDE_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [NE_MAX-1:0]   done_q, done_d;
    logic                ap_any_q, ap_any_d;
    logic [WIDE_W-1:0]   cycles_q, cycles_d;
    logic [WIDE_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]    reqcnt_q [NE_MAX];
    logic [CNT_W-1:0]    reqcnt_d [NE_MAX];

    logic [NE_MAX-1:0]   ap_m, ed_m, rq_m, done_run;
    logic                run_start, running, ar_hs, clr_rd;
    logic [31:0]         word_idx;
    logic [3:0]          eng_idx;
    logic [WIDE_W-1:0]   rd_data, cycles_base, total_base;
    logic [WIDE_W:0]     total_sum;
    logic [CNT_W-1:0]    cnt_base;
    logic [1:0]          rd_resp;
    logic [4:0]          pop;

    assign axi_l_arready = arready_q;
    assign axi_l_rvalid  = rvalid_q;
    assign axi_l_rdata   = AXIL_DATA_BITS'(rdata_q);
    assign axi_l_rresp   = rresp_q;

    // Address decode and read-data selection from the current register values
    always_comb begin
        word_idx = 32'(axi_l_araddr) >> 3;
        eng_idx  = 4'(word_idx - 32'd4);
        rd_data  = '0;
        rd_resp  = RESP_OKAY;
        ap_m     = ap_start & ENG_MASK;
        if (word_idx == 32'd0) begin
            rd_data = {32'h0, ap_m, done_q};
        end else if (word_idx == 32'd1) begin
            rd_data = cycles_q;
        end else if (word_idx == 32'd2) begin
            rd_data = total_q;
        end else if (word_idx == 32'd3) begin
            rd_data = ID_VALUE;
        end else if (word_idx < 32'd20) begin
            if (32'(eng_idx) < N_ENGINES) begin
                rd_data = {32'h0, reqcnt_q[eng_idx]};
            end
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

    // Run tracking, sticky flags and saturating counters
    always_comb begin
        ed_m      = eng_done & ENG_MASK;
        rq_m      = req_done & ENG_MASK;
        ar_hs     = axi_l_arvalid & arready_q;
`ifdef STATUS_CLEAR_ON_READ_EN
        clr_rd    = ar_hs & (word_idx == 32'd0);
`else
        clr_rd    = 1'b0;
`endif
        run_start = (|ap_m) & ~ap_any_q;
        ap_any_d  = |ap_m;
        done_run  = run_start ? '0 : done_q;
        running   = |(ap_m & ~done_run);

        done_d = ((run_start | clr_rd) ? '0 : done_q) | (ed_m & ap_m);

        cycles_base = run_start ? '0 : cycles_q;
        cycles_d    = (running && (cycles_base != '1)) ? cycles_base + 64'd1 : cycles_base;

        pop = '0;
        for (int i = 0; i < NE_MAX; i++) begin
            pop = pop + 5'(rq_m[i]);
        end
        total_base = run_start ? '0 : total_q;
        total_sum  = {1'b0, total_base} + 65'(pop);
        total_d    = total_sum[WIDE_W] ? '1 : total_sum[WIDE_W-1:0];

        cnt_base = '0;
        for (int i = 0; i < NE_MAX; i++) begin
            cnt_base    = run_start ? '0 : reqcnt_q[i];
            reqcnt_d[i] = (rq_m[i] && (cnt_base != '1)) ? cnt_base + 32'd1 : cnt_base;
        end
    end

    // Read channel FSM: capture on AR handshake, hold until R handshake
    always_comb begin
        state_d = state_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_data;
                    rresp_d  = rd_resp;
                end
            end
            RESP: begin
                if (axi_l_rready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            done_q    <= '0;
            ap_any_q  <= 1'b0;
            cycles_q  <= '0;
            total_q   <= '0;
            for (int i = 0; i < NE_MAX; i++) begin
                reqcnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            done_q    <= done_d;
            ap_any_q  <= ap_any_d;
            cycles_q  <= cycles_d;
            total_q   <= total_d;
            for (int i = 0; i < NE_MAX; i++) begin
                reqcnt_q[i] <= reqcnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_microbenchmark_status_reader.sv
// Bench for microbenchmark_status_reader: directed and random reads against a cycle-level status model.
module tb_microbenchmark_status_reader;

    logic        aclk = 1'b0;
    logic        areset;
    logic        axi_l_arvalid;
    logic [7:0]  axi_l_araddr;
    logic        axi_l_arready;
    logic        axi_l_rvalid;
    logic        axi_l_rready;
    logic [63:0] axi_l_rdata;
    logic [1:0]  axi_l_rresp;
    logic [15:0] ap_start;
    logic [15:0] eng_done;
    logic [15:0] req_done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the status block: what a host should read back
    logic [15:0] cur_ap;
    logic [15:0] m_done;
    logic        m_prev;
    logic [63:0] m_cycles;
    logic [63:0] m_total;
    logic [31:0] m_req [16];
    logic [63:0] last_rdata;

    always #5 aclk = ~aclk;

    microbenchmark_status_reader dut (
        .aclk          (aclk),
        .areset        (areset),
        .axi_l_arvalid (axi_l_arvalid),
        .axi_l_araddr  (axi_l_araddr),
        .axi_l_arready (axi_l_arready),
        .axi_l_rvalid  (axi_l_rvalid),
        .axi_l_rready  (axi_l_rready),
        .axi_l_rdata   (axi_l_rdata),
        .axi_l_rresp   (axi_l_rresp),
        .ap_start      (ap_start),
        .eng_done      (eng_done),
        .req_done      (req_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_done   = '0;
        m_prev   = 1'b0;
        m_cycles = '0;
        m_total  = '0;
        for (int i = 0; i < 16; i++) m_req[i] = '0;
    endtask

    // One clock: drive inputs, advance the model by the stated rules, wait past the edge
    task automatic step(input logic [15:0] ap, input logic [15:0] ed, input logic [15:0] rd, input logic clr);
        int pc;
        ap_start = ap;
        eng_done = ed;
        req_done = rd;
        if (ap != 0 && !m_prev) begin
            m_cycles = '0;
            m_total  = '0;
            m_done   = '0;
            for (int i = 0; i < 16; i++) m_req[i] = '0;
        end
        if (ap != 0 && (ap & ~m_done) != 0 && m_cycles != 64'hFFFF_FFFF_FFFF_FFFF)
            m_cycles = m_cycles + 64'd1;
        if (clr) m_done = '0;
        m_done = m_done | (ed & ap);
        for (int i = 0; i < 16; i++)
            if (rd[i] && m_req[i] != 32'hFFFF_FFFF) m_req[i] = m_req[i] + 32'd1;
        pc = $countones(rd);
        if (m_total > 64'hFFFF_FFFF_FFFF_FFFF - 64'(pc)) m_total = 64'hFFFF_FFFF_FFFF_FFFF;
        else m_total = m_total + 64'(pc);
        m_prev = (ap != 0);
        @(posedge aclk);
        #1;
        eng_done = '0;
        req_done = '0;
    endtask

    task automatic exp_read(input logic [7:0] addr, output logic [63:0] d, output logic [1:0] r);
        int w;
        w = int'(addr >> 3);
        d = '0;
        r = 2'b00;
        if (w == 0) d = {32'h0, cur_ap, m_done};
        else if (w == 1) d = m_cycles;
        else if (w == 2) d = m_total;
        else if (w == 3) d = 64'h0000_0000_4D42_5354;
        else if (w < 20) d = {32'h0, m_req[w-4]};
        else r = 2'b10;
    endtask

    // One read transaction; optional eng_done on the AR cycle and a stalled R beat
    task automatic rd_chk(input logic [7:0] addr, input logic [15:0] ed, input int hold, input logic rnd_rd);
        logic [63:0] ed_d;
        logic [1:0]  er;
        logic        clr;
        int          waitn;
        string       tag;
        waitn = 0;
        while (axi_l_arready !== 1'b1 && waitn < 8) begin
            step(cur_ap, 16'h0, 16'h0, 1'b0);
            waitn++;
        end
        tag = $sformatf("arready@%h", addr);
        chk(tag, 64'(axi_l_arready), 64'd1);
        exp_read(addr, ed_d, er);
        clr = 1'b0;
`ifdef STATUS_CLEAR_ON_READ_EN
        clr = (addr[7:3] == 5'd0);
`endif
        axi_l_arvalid = 1'b1;
        axi_l_araddr  = addr;
        step(cur_ap, ed, 16'h0, clr);
        axi_l_arvalid = 1'b0;
        last_rdata = axi_l_rdata;
        chk($sformatf("rvalid@%h", addr), 64'(axi_l_rvalid), 64'd1);
        chk($sformatf("rdata@%h", addr), axi_l_rdata, ed_d);
        chk($sformatf("rresp@%h", addr), 64'(axi_l_rresp), 64'(er));
        for (int h = 0; h < hold; h++) begin
            step(cur_ap, 16'h0, rnd_rd ? 16'($urandom) : 16'h0, 1'b0);
            chk($sformatf("hold_arready@%h", addr), 64'(axi_l_arready), 64'd0);
            chk($sformatf("hold_rdata@%h", addr), axi_l_rdata, ed_d);
        end
        axi_l_rready = 1'b1;
        step(cur_ap, 16'h0, 16'h0, 1'b0);
        axi_l_rready = 1'b0;
        chk($sformatf("rvalid_drop@%h", addr), 64'(axi_l_rvalid), 64'd0);
    endtask

    initial begin
        areset = 1'b1;
        axi_l_arvalid = 1'b0;
        axi_l_araddr = '0;
        axi_l_rready = 1'b0;
        ap_start = '0;
        eng_done = '0;
        req_done = '0;
        cur_ap = '0;
        last_rdata = '0;
        m_clear();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", 64'(axi_l_arready), 64'd0);
        chk("rst_rvalid", 64'(axi_l_rvalid), 64'd0);
        chk("rst_rdata", axi_l_rdata, 64'd0);
        chk("rst_rresp", 64'(axi_l_rresp), 64'd0);
        areset = 1'b0;

        rd_chk(8'h00, 16'h0, 0, 1'b0);
        rd_chk(8'h08, 16'h0, 0, 1'b0);
        rd_chk(8'h18, 16'h0, 0, 1'b0);
        chk("id_literal", last_rdata, 64'h0000_0000_4D42_5354);

        // Two-engine run: done[0] at cycle 10, done[1] at cycle 25
        cur_ap = 16'h0003;
        for (int t = 0; t < 26; t++)
            step(cur_ap, (t == 10) ? 16'h1 : ((t == 25) ? 16'h2 : 16'h0), 16'h0, 1'b0);
        repeat (4) step(cur_ap, 16'h0, 16'h0, 1'b0);
        rd_chk(8'h08, 16'h0, 0, 1'b0);
        chk("cycles_literal", last_rdata, 64'd26);
        rd_chk(8'h0C, 16'h0, 0, 1'b0);
        chk("cycles_frozen", last_rdata, 64'd26);
        rd_chk(8'h00, 16'h0, 0, 1'b0);
        chk("status_literal", last_rdata, 64'h0000_0000_0003_0003);
        rd_chk(8'h00, 16'h0002, 0, 1'b0);
        rd_chk(8'h00, 16'h0, 0, 1'b0);

        repeat (3) step(cur_ap, 16'h0, 16'hFFFF, 1'b0);
        repeat (4) step(cur_ap, 16'h0, 16'h0004, 1'b0);
        rd_chk(8'h30, 16'h0, 0, 1'b0);
        chk("reqcnt2_literal", last_rdata, 64'd7);
        rd_chk(8'h20, 16'h0, 0, 1'b0);
        chk("reqcnt0_literal", last_rdata, 64'd3);
        rd_chk(8'h10, 16'h0, 0, 1'b0);
        chk("total_literal", last_rdata, 64'd52);

        rd_chk(8'hF8, 16'h0, 0, 1'b0);
        rd_chk(8'h08, 16'h0, 0, 1'b0);

        rd_chk(8'h10, 16'h0, 5, 1'b1);
        rd_chk(8'h10, 16'h0, 0, 1'b0);

        // Run start coincident with a request pulse
        cur_ap = 16'h0;
        step(cur_ap, 16'h0, 16'h0, 1'b0);
        cur_ap = 16'h0001;
        step(cur_ap, 16'h0, 16'h0020, 1'b0);
        rd_chk(8'h48, 16'h0, 0, 1'b0);
        chk("start_and_req", last_rdata, 64'd1);
        rd_chk(8'h10, 16'h0, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0)
                cur_ap = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 2) != 0)
                step(cur_ap, 16'($urandom) & 16'($urandom), 16'($urandom), 1'b0);
            else
                rd_chk(8'($urandom), 16'($urandom) & 16'($urandom), int'($urandom_range(0, 2)),
                       1'($urandom));
        end

        // Reset while an R beat is pending drops it
        while (axi_l_arready !== 1'b1) step(cur_ap, 16'h0, 16'h0, 1'b0);
        axi_l_arvalid = 1'b1;
        axi_l_araddr  = 8'h18;
        step(cur_ap, 16'h0, 16'h0, 1'b0);
        axi_l_arvalid = 1'b0;
        areset = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_drop_rvalid", 64'(axi_l_rvalid), 64'd0);
        chk("rst_drop_rdata", axi_l_rdata, 64'd0);
        areset = 1'b0;
        cur_ap = 16'h0;
        ap_start = 16'h0;
        m_clear();
        rd_chk(8'h10, 16'h0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
